// File: rtl/spram_weight_reader.sv
// Burst reader: streams len words from a single-port RAM into a credit-limited output FIFO.
// Optional macro SPRAM_RD_WRAP_EN: addresses wrap modulo DEPTH instead of rejecting overruns.
module spram_weight_reader #(
    parameter int DW     = 64,
    parameter int AW     = 8,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
);
    localparam int FD = RD_LAT + 2;
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [CW:0] FD_W    = (CW+1)'(FD);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [AW:0]       remain;
    logic [RD_LAT-1:0] tags;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [DW-1:0]     fifo [FD];

    logic [AW:0] len_eff;
    logic [CW:0] occ;
    logic        overrun;
    logic        issue;
    logic        last_issue;
    logic        push;
    logic        pop;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
`ifdef SPRAM_RD_WRAP_EN
        return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
`else
        return a + 1'b1;
`endif
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_eff = (len > DEPTH_W) ? DEPTH_W : len;

`ifdef SPRAM_RD_WRAP_EN
    assign overrun = 1'b0;
`else
    logic [AW+1:0] end_addr;
    assign end_addr = (AW+2)'(base) + (AW+2)'(len_eff);
    assign overrun  = end_addr > (AW+2)'(DEPTH);
`endif

    // Credit: FIFO words plus reads still in the RAM pipeline never exceed the FIFO depth.
    assign inflight   = CW'($countones(tags));
    assign occ        = {1'b0, count} + {1'b0, inflight};
    assign issue      = (state == READ) && (remain != '0) && (occ < FD_W);
    assign last_issue = issue && (remain == (AW+1)'(1));
    assign push       = tags[RD_LAT-1];
    assign pop        = m_valid && m_ready;

    assign m_valid = (count != '0);
    assign m_data  = fifo[rd_ptr];
    assign mem_we  = 1'b0;

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        mem_cs   = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ((len_eff == '0) || overrun) ? DONE : READ;
            end
            READ: begin
                busy   = 1'b1;
                mem_cs = 1'b1;
                if (last_issue) state_nx = DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                mem_cs = 1'b1;
                if ((count == '0) && (tags == '0)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            remain   <= '0;
            mem_addr <= '0;
            err      <= 1'b0;
            tags     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < FD; i++) fifo[i] <= '0;
        end else begin
            state <= state_nx;
            if ((state == IDLE) && start) begin
                mem_addr <= base;
                remain   <= len_eff;
                err      <= overrun;
            end else if (issue) begin
                mem_addr <= addr_inc(mem_addr);
                remain   <= remain - 1'b1;
            end
            // Tag reaches the top bit exactly when the RAM presents that read's data.
            tags <= (tags << 1) | RD_LAT'(issue);
            if (push) begin
                fifo[wr_ptr] <= mem_rdata;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_spram_weight_reader.sv
// Bench for spram_weight_reader: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// checked against a burst-level model of read addresses, output order, occupancy and done/err.
`timescale 1ns/1ps
module tb_spram_weight_reader;
    localparam int DW = 64, AW = 8, DEPTH = 256, NI = 2;

    logic          clk = 1'b0, rstn = 1'b1, start = 1'b0, m_ready = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;

    logic          busy [NI], done [NI], err [NI], mem_cs [NI], mem_we [NI], m_valid [NI];
    logic [AW-1:0] mem_addr [NI];
    logic [DW-1:0] mem_rdata [NI], m_data [NI];

    int n_cmp = 0, n_fail = 0, cyc = 0, rmode = 0, rp = 0, start_cyc = 0;

    int   exp_base [NI], exp_cnt [NI], got [NI], issued [NI], dones [NI];
    int   first_busy [NI], first_valid [NI], last_pop [NI], done_cyc [NI];
    logic exp_err [NI], open_b [NI], saw_cs [NI], saw_valid [NI];
    logic [DW-1:0] cap [NI][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int g, input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (inst %0d): actual %0h required %0h", name, g, act, req);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gd
        localparam int L = (g == 0) ? 1 : 3;
        logic [DW-1:0] pipe [L];
        logic [AW-1:0] prev_addr = '0;
        logic          prev_cs = 1'b0;

        spram_weight_reader #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(L)) dut (
            .clk(clk), .rstn(rstn), .start(start), .base(base), .len(len),
            .busy(busy[g]), .done(done[g]), .err(err[g]),
            .mem_cs(mem_cs[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_rdata(mem_rdata[g]), .m_valid(m_valid[g]), .m_ready(m_ready),
            .m_data(m_data[g]));

        // RAM[i] = i with an L-stage read pipeline; garbage when deselected
        always @(posedge clk) begin
            pipe[0] <= mem_cs[g] ? DW'(mem_addr[g]) : 64'hDEAD_BEEF_DEAD_BEEF;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[L-1];

        always @(negedge clk) begin
            if (rstn) begin
                check(g, "mem_we", 64'(mem_we[g]), 64'd0);
                check(g, "cs_eq_busy", 64'(mem_cs[g]), 64'(busy[g]));
                if (mem_cs[g]) saw_cs[g] = 1'b1;
                if (busy[g] && first_busy[g] < 0) first_busy[g] = cyc;
                if (prev_cs && mem_addr[g] != prev_addr) begin
                    check(g, "issue_in_burst", 64'(issued[g] < exp_cnt[g]), 64'd1);
                    check(g, "issue_addr", 64'(prev_addr), 64'((exp_base[g] + issued[g]) % DEPTH));
                    issued[g]++;
                end
                check(g, "occupancy", 64'(issued[g] - got[g] <= L + 2), 64'd1);
                if (m_valid[g]) begin
                    saw_valid[g] = 1'b1;
                    if (first_valid[g] < 0) first_valid[g] = cyc;
                end
                if (m_valid[g] && m_ready) begin
                    check(g, "word_in_burst", 64'(got[g] < exp_cnt[g]), 64'd1);
                    check(g, "data", m_data[g], 64'((exp_base[g] + got[g]) % DEPTH));
                    if (got[g] < 16) cap[g][got[g]] = m_data[g];
                    got[g]++;
                    last_pop[g] = cyc;
                end
                if (done[g]) begin
                    check(g, "done_expected", 64'(open_b[g]), 64'd1);
                    check(g, "err", 64'(err[g]), 64'(exp_err[g]));
                    check(g, "all_words", 64'(got[g]), 64'(exp_cnt[g]));
                    dones[g]++;
                    done_cyc[g] = cyc;
                    open_b[g] = 1'b0;
                end
            end
            prev_cs   = mem_cs[g];
            prev_addr = mem_addr[g];
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0: m_ready = 1'b1;
            1: begin m_ready = (rp % 3 == 0); rp++; end
            2: m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic clear_model();
        for (int g = 0; g < NI; g++) begin
            exp_base[g] = 0; exp_cnt[g] = 0; exp_err[g] = 1'b0; got[g] = 0; issued[g] = 0;
            dones[g] = 0; open_b[g] = 1'b0; saw_cs[g] = 1'b0; saw_valid[g] = 1'b0;
            first_busy[g] = -1; first_valid[g] = -1; last_pop[g] = -1; done_cyc[g] = -1;
        end
    endtask

    task automatic check_reset_outputs();
        for (int g = 0; g < NI; g++) begin
            check(g, "rst_busy", 64'(busy[g]), 64'd0);
            check(g, "rst_done", 64'(done[g]), 64'd0);
            check(g, "rst_err", 64'(err[g]), 64'd0);
            check(g, "rst_mem_cs", 64'(mem_cs[g]), 64'd0);
            check(g, "rst_m_valid", 64'(m_valid[g]), 64'd0);
            check(g, "rst_mem_addr", 64'(mem_addr[g]), 64'd0);
            check(g, "rst_m_data", m_data[g], 64'd0);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy[0] || busy[1] || done[0] || done[1]) && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        check(-1, "idle_timeout", 64'(t < 3000), 64'd1);
    endtask

    task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
        int  le;
        bit  ovf;
        le = (int'(l) > DEPTH) ? DEPTH : int'(l);
`ifdef SPRAM_RD_WRAP_EN
        ovf = 1'b0;
`else
        ovf = (int'(b) + le > DEPTH);
`endif
        clear_model();
        for (int g = 0; g < NI; g++) begin
            exp_base[g] = int'(b); exp_cnt[g] = ovf ? 0 : le; exp_err[g] = ovf; open_b[g] = 1'b1;
        end
        start_cyc = cyc;
        base = b; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!(dones[0] > 0 && dones[1] > 0) && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        check(-1, "done_timeout", 64'(t < 3000), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) check(g, "done_count", 64'(dones[g]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w20 [4];
        logic [DW-1:0] wfe [4];
        w20 = '{64'h10, 64'h11, 64'h12, 64'h13};
        wfe = '{64'hFE, 64'hFF, 64'h00, 64'h01};
        clear_model();
        #2 rstn = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Basic burst, ready always high
        rmode = 0;
        wait_idle();
        launch(8'h10, 9'd4);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            check(0, "req020_word", cap[0][i], w20[i]);
            check(1, "req020_word", cap[1][i], w20[i]);
        end
        check(0, "latency", 64'(first_valid[0] - first_busy[0]), 64'd2);
        check(1, "latency", 64'(first_valid[1] - first_busy[1]), 64'd4);
        for (int g = 0; g < NI; g++) begin
            check(g, "back_to_back", 64'(last_pop[g] - first_valid[g]), 64'd3);
            check(g, "done_after_empty", 64'(done_cyc[g] - last_pop[g]), 64'd2);
        end

        // Backpressure 1,0,0 pattern
        rmode = 1; rp = 0;
        wait_idle();
        launch(8'h40, 9'd8);
        wait_done();

        // Zero-length burst
        rmode = 0;
        wait_idle();
        launch(8'h00, 9'd0);
        wait_done();
        for (int g = 0; g < NI; g++) begin
            check(g, "len0_done_delay", 64'(done_cyc[g] - start_cyc), 64'd1);
            check(g, "len0_no_cs", 64'(saw_cs[g]), 64'd0);
            check(g, "len0_no_valid", 64'(saw_valid[g]), 64'd0);
        end

        // Burst crossing the top of memory
        wait_idle();
        launch(8'hFE, 9'd4);
        wait_done();
        for (int g = 0; g < NI; g++) begin
`ifdef SPRAM_RD_WRAP_EN
            for (int i = 0; i < 4; i++) check(g, "wrap_word", cap[g][i], wfe[i]);
`else
            check(g, "ovf_no_reads", 64'(issued[g]), 64'd0);
            check(g, "ovf_no_cs", 64'(saw_cs[g]), 64'd0);
            check(g, "ovf_err", 64'(err[g]), 64'd1);
`endif
        end

        // Length above DEPTH is clamped
        rmode = 3;
        wait_idle();
        launch(8'h00, 9'd300);
        wait_done();
        wait_idle();
        launch(8'h01, 9'd300);
        wait_done();

        // Start while busy is ignored
        wait_idle();
        launch(8'h80, 9'd6);
        @(posedge clk); #1;
        base = 8'h20; len = 9'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // Reset in the middle of a stalled burst
        rmode = 2;
        wait_idle();
        launch(8'h30, 9'd8);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) check(g, "busy_before_rst", 64'(busy[g]), 64'd1);
        #2;
        clear_model();
        rstn = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk); #1;
        rstn = 1'b1;
        rmode = 0;
        repeat (10) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check(g, "rst_no_done", 64'(dones[g]), 64'd0);
            check(g, "rst_no_leftover", 64'(got[g]), 64'd0);
        end
        wait_idle();
        launch(8'h50, 9'd5);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/spram_weight_reader.md
SPRAM_WEIGHT_READER -- requirements
Module: spram_weight_reader

Interface
REQ-001 SHALL have parameters: DW, 64, data word width; AW, 8, address width; DEPTH, 256, RAM word count; RD_LAT, 1, RAM read latency in cycles (legal 1..4).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that launches a burst.
- base  in  AW  first word address of the burst.
- len  in  AW+1  number of words in the burst (0..DEPTH).
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the burst completes.
- err  out  1  error flag for the last burst, valid with done.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_rdata  in  DW  RAM read data.
- m_valid  out  1  output stream data valid.
- m_ready  in  1  output stream ready.
- m_data  out  DW  output stream data.

Function
REQ-003 SHALL drive mem_we constantly 0; the block is read-only.
REQ-004 SHALL sample base and len on start only in IDLE; start while busy SHALL be ignored.
REQ-005 SHALL implement the states IDLE, READ, DRAIN and DONE.
- IDLE->READ on start with len>0.
- IDLE->DONE on start with len==0.
- READ->DRAIN when the last read is issued.
- DRAIN->DONE when the FIFO is empty and no read is in flight.
- DONE->IDLE unconditionally after one cycle.
REQ-006 SHALL assert mem_cs continuously in READ and DRAIN, so the RAM read pipeline advances every cycle; mem_cs SHALL be 0 in IDLE and DONE.
REQ-007 A read SHALL issue in a READ cycle when (fifo_count + inflight) < RD_LAT+2.
- On issue, mem_addr advances by 1 and the remaining count decrements by 1.
- mem_addr SHALL equal base in the first READ cycle.
REQ-008 SHALL keep a RD_LAT-deep valid shift register of issue tags. The mem_rdata value present RD_LAT cycles after a tagged issue SHALL be pushed into the FIFO; untagged returns SHALL be discarded.
REQ-009 SHALL contain an output FIFO of depth RD_LAT+2. The credit rule of REQ-007 SHALL guarantee it never overflows.
REQ-010 The FIFO SHALL support push and pop in the same cycle.
- m_data SHALL be the FIFO head.
- m_valid SHALL equal FIFO not empty.
- A word is popped when m_valid and m_ready are both high.
REQ-011 Words SHALL leave the output in address order, with no loss or duplication, under any m_ready pattern.
REQ-012 With m_ready held high, SHALL sustain one word per cycle after an initial latency of RD_LAT+1 cycles from the first READ cycle.
REQ-013 busy SHALL be high in READ and DRAIN; done SHALL be high only in DONE.
REQ-014 m_valid, m_data, mem_addr and done SHALL not depend combinationally on m_ready.

Reset
REQ-015 On rstn low, the block SHALL immediately enter IDLE and clear the following:
- busy, done, err, mem_cs, m_valid = 0
- mem_addr = 0, m_data = 0
- FIFO, tags and counters = 0
REQ-016 Reset mid-burst SHALL abandon the burst without a done pulse; data already in flight SHALL be discarded.

Configuration
REQ-017 Macro SPRAM_RD_WRAP_EN defined: mem_addr SHALL increment modulo DEPTH (DEPTH-1 -> 0), and err SHALL always be 0.
REQ-018 Macro SPRAM_RD_WRAP_EN undefined: a start with base+len > DEPTH SHALL go directly IDLE->DONE with err=1 and issue no reads; otherwise err=0.
REQ-019 Any start with len > DEPTH SHALL be treated as len == DEPTH.

Verification
REQ-020 With base=0x10, len=4, m_ready=1 and RAM[i]=i, SHALL output 0x10, 0x11, 0x12, 0x13 on consecutive cycles, followed by done=1 and err=0.
REQ-021 With len=8 and m_ready toggling 1,0,0,1,..., SHALL deliver all 8 words in order with no drop and FIFO count never above RD_LAT+2; run with RD_LAT=1 and RD_LAT=3.
REQ-022 With len=0, SHALL produce done one cycle after start, with mem_cs never asserted and m_valid never asserted.
REQ-023 With base=0xFE and len=4, SHALL read 0xFE, 0xFF, 0x00, 0x01 with err=0 when the macro is defined; when undefined, SHALL pulse done with err=1 and issue no reads.
REQ-024 With rstn pulsed low during READ and m_ready=0, SHALL drop all outputs to 0 asynchronously; a subsequent start SHALL run a clean burst.
REQ-025 With start re-asserted during busy, SHALL leave the burst unchanged and produce exactly one done.
